horizontal_tf_mul: RTL

Pipelined Goldilocks-field (p = 2^64 − 2^32 + 1) twiddle multiplier for the row-0 horizontal twiddle path of the radix-16, 16384-point BFFTP.
- Consumes one butterfly output word and the matching horizontal twiddle factor each cycle, and returns the canonical product mod p.
- Tags every 16th result with a group-end marker.
- Sits directly downstream of the horizontal twiddle-factor generator and the row-0 radix-16 butterfly, and upstream of the transpose memory.

---
 rtl/ff_pkg.sv | 12 +
 rtl/goldilocks_reduce.sv | 32 +++
 rtl/horizontal_tf_mul.sv | 99 +++++++++
 3 files changed

// File: rtl/ff_pkg.sv
// ff_pkg: Goldilocks field constants and word type shared by the twiddle multiplier.
// Contents:
//   GL_P    - field modulus p = 2^64 - 2^32 + 1
//   GL_EPS  - 2^32 - 1, the value 2^64 reduces to mod p
//   P_WIDTH - field word width
//   fe_t    - field word type
package ff_pkg;
   localparam int P_WIDTH = 64;
   localparam logic [63:0] GL_P = 64'hFFFF_FFFF_0000_0001;
   localparam logic [63:0] GL_EPS = 64'h0000_0000_FFFF_FFFF;
   typedef logic [P_WIDTH-1:0] fe_t;
endpackage

// File: rtl/goldilocks_reduce.sv
// goldilocks_reduce: combinational reduction of a 128-bit product to a canonical Goldilocks word.
// Ports:
//   x - 128-bit product, split as h1*2^96 + h0*2^64 + lo
//   r - x mod p, in [0, p)
module goldilocks_reduce
   import ff_pkg::*;
(
   input  logic [127:0] x,
   output fe_t          r
);
   fe_t         lo;
   logic [31:0] h0;
   logic [31:0] h1;
   logic [64:0] diff;
   fe_t         t0;
   fe_t         t1;
   logic [64:0] sum;
   fe_t         t2;
   assign lo = x[63:0];
   assign h0 = x[95:64];
   assign h1 = x[127:96];
   // 2^96 = -1, so h1 is subtracted; a borrow wraps by adding p back.
   assign diff = {1'b0, lo} - {33'b0, h1};
   assign t0 = diff[64] ? diff[63:0] + GL_P : diff[63:0];
   // 2^64 = 2^32 - 1, so h0 contributes h0*2^32 - h0 (never negative).
   assign t1 = {h0, 32'b0} - {32'b0, h0};
   // A carry out of bit 64 stands for 2^64, i.e. another 2^32 - 1; this add cannot overflow again.
   assign sum = {1'b0, t0} + {1'b0, t1};
   assign t2 = sum[64] ? sum[63:0] + GL_EPS : sum[63:0];
   // t2 < 2^64 < 2p, so a single conditional subtract makes it canonical.
   assign r = (t2 >= GL_P) ? t2 - GL_P : t2;
endmodule

// File: rtl/horizontal_tf_mul.sv
// horizontal_tf_mul: pipelined Goldilocks twiddle multiplier with group-end marker for the row-0 horizontal path.
// Ports:
//   clk       - clock
//   rst_n     - asynchronous reset, active high despite its name
//   CEN       - active-low pipeline enable; high freezes every register
//   in_valid  - in_data and tf valid this cycle
//   in_data   - butterfly output word (canonical)
//   tf        - twiddle factor (canonical)
//   out_valid - out_data valid
//   out_data  - (in_data * tf) mod p
//   out_last  - marks every 16th valid output
// Build option: TF_MUL_OUT_REG_EN adds an output register after the reduction (latency 4 instead of 3).
module horizontal_tf_mul #(
   parameter int P_WIDTH      = 64,
   parameter int GRP_LEN_LOG2 = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               CEN,
   input  logic               in_valid,
   input  logic [P_WIDTH-1:0] in_data,
   input  logic [P_WIDTH-1:0] tf,
   output logic               out_valid,
   output logic [P_WIDTH-1:0] out_data,
   output logic               out_last
);
   import ff_pkg::*;
   fe_t                     a;
   fe_t                     b;
   logic                    v1;
   logic                    v2;
   logic                    v3;
   logic                    last3;
   logic [127:0]            x;
   logic [127:0]            x_c;
   logic [63:0]             pll;
   logic [63:0]             plh;
   logic [63:0]             phl;
   logic [63:0]             phh;
   fe_t                     r_c;
   fe_t                     r3;
   logic [GRP_LEN_LOG2-1:0] cnt;
   assign pll = 64'(a[31:0]) * 64'(b[31:0]);
   assign plh = 64'(a[31:0]) * 64'(b[63:32]);
   assign phl = 64'(a[63:32]) * 64'(b[31:0]);
   assign phh = 64'(a[63:32]) * 64'(b[63:32]);
   assign x_c = {64'b0, pll} + {32'b0, plh, 32'b0} + {32'b0, phl, 32'b0} + {phh, 64'b0};
   goldilocks_reduce u_reduce (
      .x (x),
      .r (r_c)
   );
`ifdef TF_MUL_OUT_REG_EN
   fe_t  od;
   logic ov;
   logic ol;
   assign out_data  = od;
   assign out_valid = ov;
   assign out_last  = ol;
`else
   assign out_data  = r3;
   assign out_valid = v3;
   assign out_last  = last3;
`endif
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         a     <= '0;
         b     <= '0;
         v1    <= 1'b0;
         x     <= '0;
         v2    <= 1'b0;
         r3    <= '0;
         v3    <= 1'b0;
         last3 <= 1'b0;
         cnt   <= '0;
`ifdef TF_MUL_OUT_REG_EN
         od    <= '0;
         ov    <= 1'b0;
         ol    <= 1'b0;
`endif
      end else if (!CEN) begin
         a     <= in_data;
         b     <= tf;
         v1    <= in_valid;
         x     <= x_c;
         v2    <= v1;
         r3    <= r_c;
         v3    <= v2;
         // The counter tracks valid words entering the stage-3 register, so the
         // marker lands on the word that takes the count from all-ones back to zero.
         last3 <= v2 && (cnt == '1);
         if (v2) cnt <= cnt + GRP_LEN_LOG2'(1);
`ifdef TF_MUL_OUT_REG_EN
         od    <= r3;
         ov    <= v3;
         ol    <= last3;
`endif
      end
   end
endmodule
